// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : signal bundle between the UART receiver and its environment.
//
//   ena        oversample tick into the receiver (one clk wide)
//   rx         raw serial line into the receiver (asynchronous to clk)
//   data       last good received word
//   valid      one-clk pulse, data is new this cycle
//   frame_err  one-clk pulse, stop bit sampled low
//   parity_err one-clk pulse, parity mismatch (0 unless parity build)
//   busy       receiver is inside a frame (state != IDLE)
//
// modport master : the receiver itself (drives the result signals)
// modport slave  : the consumer / line side (drives ena and rx)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 ena;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  ena,
    input  rx,
    output data,
    output valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output ena,
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver.
//
// Frame: idle high, one start bit (0), DATA_BITS data bits LSB first,
// optional even-parity bit, one stop bit (1). The line is sampled once per
// ena tick; the start bit is revalidated at its middle and every following
// bit is sampled OVERSAMPLE ticks later, i.e. at its own middle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.master : ena, rx in; data, valid, frame_err,
//          parity_err, busy out
//
// Parameters:
//   OVERSAMPLE  ena ticks per bit period (even, >= 4)
//   DATA_BITS   data bits per frame (5..8)
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. Without it parity_err is tied to 0.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_db
    $error("uart_rx: DATA_BITS must be in 5..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchronizer; both stages reset to the idle (high) level so
  // reset release never looks like a start edge.
  logic rx_meta_q;
  logic rx_s_q;

  state_t               state_q,  state_d;
  logic [TW-1:0]        tick_q,   tick_d;
  logic [BW-1:0]        bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q,    par_d;
  logic                 perr_q,   perr_d;

  // Even parity: the transmitted bit equals the XOR of the data bits.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] w,
                                     input logic                 p);
    return ((^w) == p);
  endfunction
`endif

  // Input synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic; nothing moves except on an ena tick, and the result
  // pulses are cleared every clk so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end

        // Half a bit after the falling edge the line must still be low,
        // otherwise the edge was a glitch and is dropped silently.
        S_START: begin
          if (tick_q == TICK_MID) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        // Shift right with the new bit entering at the MSB: after the last
        // bit the first (LSB) bit has arrived at position 0.
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            par_d   = rx_s_q;
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif

        // Decide at mid stop bit and return to IDLE right away so a start
        // bit immediately following the stop bit is not missed. A framing
        // error outranks a parity error.
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end else begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (parity_ok(shift_q, par_q)) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                perr_d = 1'b1;
              end
`else
              data_d  = shift_q;
              valid_d = 1'b1;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        // Line held low after a bad stop bit: wait for it to go idle so a
        // break produces a single frame_err instead of a stream of frames.
        S_BREAK: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed bench for uart_rx with ena asserted every clk
// (OVERSAMPLE=16 clks per bit). Line stimulus changes on falling clk edges;
// a monitor on the falling edge counts result pulses and records each
// received word and the cycle it arrived on.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_CLKS = OS * (DB + 2 + PB);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  int         cyc  = 0;
  int         vcnt = 0;
  int         fcnt = 0;
  int         pcnt = 0;
  int         both = 0;
  int         bcyc = 0;
  logic [7:0] vdata [64];
  int         vcyc  [64];

  always @(negedge clk) begin
    cyc++;
    if (bus.valid) begin
      if (vcnt < 64) begin
        vdata[vcnt] = bus.data;
        vcyc[vcnt]  = cyc;
      end
      vcnt++;
    end
    if (bus.frame_err) fcnt++;
    if (bus.parity_err) pcnt++;
    if (bus.valid && bus.frame_err) both++;
    if (bus.busy) bcyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  // Frame with correct parity (when parity is built in) and chosen stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) hold(d[i], OS);
`ifdef UART_RX_PARITY_EN
    hold(^d, OS);
`endif
    hold(stop_b, OS);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) hold(d[i], OS);
    hold(par_b, OS);
    hold(1'b1, OS);
  endtask
`endif

  initial begin
    int v0;
    int f0;
    int b0;
    int p0;
    logic [7:0] w;

    bus.ena = 1'b1;
    bus.rx  = 1'b1;
    rst_n   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_parity_err", bus.parity_err, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Single frame 0xA5
    v0 = vcnt; f0 = fcnt;
    send_frame(8'hA5, 1'b1);
    idle(4);
    #1;
    chk("a5_valid_cnt", vcnt - v0, 1);
    chk("a5_word", vdata[v0], 8'hA5);
    chk("a5_data_out", bus.data, 8'hA5);
    chk("a5_frame_err_cnt", fcnt - f0, 0);
    chk("a5_busy_after", bus.busy, 0);

    // Back-to-back 0x00, 0xFF with no idle gap
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    #1;
    chk("b2b_valid_cnt", vcnt - v0, 2);
    chk("b2b_word0", vdata[v0], 8'h00);
    chk("b2b_word1", vdata[v0 + 1], 8'hFF);
    chk("b2b_spacing", vcyc[v0 + 1] - vcyc[v0], FRAME_CLKS);

    // Line low while ena is held off: receiver must not leave IDLE
    bus.ena = 1'b0;
    hold(1'b0, 20);
    #1;
    chk("ena_off_busy", bus.busy, 0);
    idle(4);
    bus.ena = 1'b1;
    idle(5);

    // 4-tick glitch: START for 8 ticks then back to IDLE, no pulses
    v0 = vcnt; f0 = fcnt; b0 = bcyc;
    hold(1'b0, 4);
    idle(30);
    #1;
    chk("glitch_valid_cnt", vcnt - v0, 0);
    chk("glitch_frame_err_cnt", fcnt - f0, 0);
    chk("glitch_busy_cycles", bcyc - b0, 8);
    v0 = vcnt;
    send_frame(8'h3C, 1'b1);
    idle(4);
    #1;
    chk("3c_valid_cnt", vcnt - v0, 1);
    chk("3c_data_out", bus.data, 8'h3C);

    // 0x55 with stop bit low, line then held low (break)
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 40);
    #1;
    chk("brk_frame_err_cnt", fcnt - f0, 1);
    chk("brk_valid_cnt", vcnt - v0, 0);
    chk("brk_data_kept", bus.data, 8'h3C);
    chk("brk_busy_held", bus.busy, 1);
    idle(10);
    #1;
    chk("brk_busy_released", bus.busy, 0);
    chk("brk_frame_err_once", fcnt - f0, 1);

    // Reset in the middle of data bit 4 of a 0x81 frame
    w  = 8'h81;
    v0 = vcnt; f0 = fcnt;
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(w[i], OS);
    hold(w[4], OS / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_frame_err", bus.frame_err, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(OS * 12);
    #1;
    chk("abort_valid_cnt", vcnt - v0, 0);
    chk("abort_frame_err_cnt", fcnt - f0, 0);
    send_frame(8'h81, 1'b1);
    idle(4);
    #1;
    chk("81_valid_cnt", vcnt - v0, 1);
    chk("81_data_out", bus.data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    v0 = vcnt; f0 = fcnt; p0 = pcnt;
    send_frame_par(8'h07, 1'b0);
    idle(4);
    #1;
    chk("par_bad_perr_cnt", pcnt - p0, 1);
    chk("par_bad_valid_cnt", vcnt - v0, 0);
    chk("par_bad_frame_err_cnt", fcnt - f0, 0);
    chk("par_bad_data_kept", bus.data, 8'h81);
    v0 = vcnt; p0 = pcnt;
    send_frame_par(8'h07, 1'b1);
    idle(4);
    #1;
    chk("par_good_valid_cnt", vcnt - v0, 1);
    chk("par_good_perr_cnt", pcnt - p0, 0);
    chk("par_good_data_out", bus.data, 8'h07);
`else
    p0 = pcnt;
    chk("no_parity_err_ever", p0, 0);
`endif

    chk("valid_and_frame_err_overlap", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the UART transmit FSM on the same link. Frame: idle high, 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Samples the line on an oversample tick, validates the start bit, and shifts in the data bits.
- Presents each received byte with a one-cycle valid pulse, plus framing-error reporting, to the consumer logic.

Parameters:
- OVERSAMPLE, 16, ena ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  oversample tick, one clk wide, OVERSAMPLE per bit period.
- rx  input  1  serial line, asynchronous to clk.
- data  output  DATA_BITS  last good received word.
- valid  output  1  one-clk pulse; data is new this cycle.
- frame_err  output  1  one-clk pulse; stop bit sampled 0.
- parity_err  output  1  one-clk pulse; parity mismatch (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - data = 0; valid, frame_err, parity_err, busy = 0.
  - State = IDLE, counters = 0.
  - Both synchronizer flops = 1 (line idle).
- rx passes through a 2-flop synchronizer; every use below means the synchronized value rx_s.
- All counting and sampling advances only on clk edges where ena = 1. Outputs pulse on the clk edge of the deciding ena.
- Counters:
  - tick_cnt: 0..OVERSAMPLE-1, width clog2(OVERSAMPLE).
  - bit_cnt: 0..DATA_BITS-1.
- States and transitions:
  - IDLE: on ena with rx_s = 0 -> START, tick_cnt = 0.
  - START: on ena, tick_cnt++. When tick_cnt reaches OVERSAMPLE/2-1 (mid start bit), resample rx_s.
    - rx_s = 1: glitch; -> IDLE, no output pulse.
    - rx_s = 0: -> DATA, tick_cnt = 0, bit_cnt = 0.
  - DATA: on ena, tick_cnt++. At tick_cnt = OVERSAMPLE-1 (mid-bit):
    - Shift rx_s into the MSB of shift_reg (shift right, so LSB-first reception fills correctly); tick_cnt = 0.
    - If bit_cnt = DATA_BITS-1 -> STOP (or PARITY with macro); else bit_cnt++.
  - STOP: at mid-bit (tick_cnt = OVERSAMPLE-1):
    - rx_s = 1: data <= shift_reg; valid = 1 for one clk; -> IDLE.
    - rx_s = 0: frame_err = 1 for one clk; data unchanged; -> BREAK.
  - BREAK: stay until an ena with rx_s = 1, then -> IDLE. A held-low line (break) yields exactly one frame_err.
- Latency: valid asserts at the middle of the stop bit, 2 clk + (DATA_BITS+1.5) bit periods after the start-bit falling edge.
- The receiver returns to IDLE mid stop bit, so back-to-back frames with zero idle time are received without loss.
- Boundary conditions:
  - ena = 0: all state holds.
  - rx changes between ticks: ignored.
  - valid and frame_err are never high together.
  - Mid-frame reset discards the partial word; data returns to 0.
  - Line low at reset release: enters START on the first ena and follows the normal start validation.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is added between DATA and STOP, sampled at mid-bit like the data bits.
  - Even parity: expected bit = XOR of the data bits.
  - On mismatch: parity_err pulses at the stop-bit decision cycle, valid is suppressed, data is unchanged. The receiver still checks the stop bit; frame_err has priority if both fail.
- Not defined: no PARITY state; parity_err is tied to 0; frame length is 1+DATA_BITS+1.

Test Plan:
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with OVERSAMPLE=16 and ena every clk -> exactly one valid pulse, data = 0xA5, frame_err = 0, busy low after the pulse.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, 160 ena ticks apart, data = 0x00 then 0xFF.
- Low glitch of 4 ticks on an idle line -> no valid and no frame_err; busy high for ~8 ticks then low; a following frame 0x3C is received correctly.
- Frame 0x55 with stop bit forced 0, line then held low for 40 ticks -> one frame_err pulse, no valid, data keeps its previous value, state stays BREAK until rx = 1.
- Assert rst_n = 0 mid data bit 4 of a frame, release, then send 0x81 -> outputs 0 during reset, no pulse from the aborted frame, then data = 0x81 with valid.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong; expected 1) -> parity_err pulse, no valid. Send 0x07 with parity bit 1 -> valid, data = 0x07.
